// File: rtl/shift_pkg.sv
// Shared types and defaults for the shift command sequencer.
// Mode codes, command bundle layout, depth/width defaults.
package shift_pkg;

  localparam int DEF_DEPTH = 4;
  localparam int DEF_W     = 4;

  // mode(2) + amt(2) + ser(1) + rep(3) bits beside data
  localparam int CTL_W = 8;

  typedef enum logic [1:0] {
    HOLD = 2'b00,
    SHR  = 2'b01,
    SHL  = 2'b10,
    ROT  = 2'b11
  } mode_e;

  typedef struct packed {
    logic [DEF_W-1:0] data;
    mode_e            mode;
    logic [1:0]       amt;
    logic             ser;
    logic [2:0]       rep;
  } cmd_t;

endpackage

// File: rtl/shift_cmd_fifo.sv
// In-order command queue: storage, wrapping pointers, occupancy.
// Ports: clk, reset, i_clr/i_push/i_pop, i_data -> o_data, o_empty, o_full.
module shift_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_clr,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [DW-1:0] i_data,
  output logic [DW-1:0] o_data,
  output logic          o_empty,
  output logic          o_full
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_data  = r_mem[r_rptr];

  assign w_push = i_push && !o_full && !i_clr;
  assign w_pop  = i_pop && !o_empty && !i_clr;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  // DEPTH is a power of two, so pointers wrap naturally
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_clr) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop) r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/shift_cmd_seq.sv
// Command sequencer: queues shift commands, issues each rep+1 cycles.
// Ports: cmd_* handshake in, flush; load/in/ch/sh/rg/busy/done out.
module shift_cmd_seq
  import shift_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int W     = DEF_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [W-1:0] cmd_data,
  input  logic [1:0]   cmd_mode,
  input  logic [1:0]   cmd_amt,
  input  logic         cmd_ser,
  input  logic [2:0]   cmd_rep,
  input  logic         flush,
  output logic         load,
  output logic [W-1:0] in,
  output logic [1:0]   ch,
  output logic [1:0]   sh,
  output logic         rg,
  output logic         busy,
  output logic         done
);

  localparam int CW = W + CTL_W;
  localparam int IW = W + 5;

  typedef enum logic {
    S_IDLE,
    S_ISSUE
  } state_e;

  state_e        r_state;
  state_e        w_state_nx;
  logic [2:0]    r_rcnt;
  logic [2:0]    w_rcnt_nx;
  logic [IW-1:0] r_issue;
  logic [IW-1:0] w_issue_nx;
  logic [CW-1:0] w_cmd;
  logic [CW-1:0] w_head;
  logic          w_empty;
  logic          w_full;
  logic          w_acc;
  logic          w_push;
  logic          w_pop;

  assign w_cmd = {cmd_data, cmd_mode,
                  cmd_amt, cmd_ser, cmd_rep};

  assign cmd_ready = !reset && !flush && !w_full;
  assign w_acc     = cmd_valid && cmd_ready;

  shift_cmd_fifo #(
    .DEPTH (DEPTH),
    .DW    (CW)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_clr   (flush),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_cmd),
    .o_data  (w_head),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_rcnt  <= '0;
      r_issue <= '0;
    end else begin
      r_state <= w_state_nx;
      r_rcnt  <= w_rcnt_nx;
      r_issue <= w_issue_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_rcnt_nx  = r_rcnt;
    w_issue_nx = r_issue;
    w_push     = 1'b0;
    w_pop      = 1'b0;
    if (flush) begin
      w_state_nx = S_IDLE;
      w_rcnt_nx  = '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            w_pop      = 1'b1;
            w_push     = w_acc;
            w_issue_nx = w_head[CW-1:3];
            w_rcnt_nx  = w_head[2:0];
            w_state_nx = S_ISSUE;
          end else if (w_acc) begin
            w_issue_nx = w_cmd[CW-1:3];
            w_rcnt_nx  = cmd_rep;
            w_state_nx = S_ISSUE;
          end
        end
        S_ISSUE: begin
          w_push = w_acc;
          if (r_rcnt != 3'd0) begin
            w_rcnt_nx = r_rcnt - 3'd1;
          end else if (!w_empty) begin
            w_pop      = 1'b1;
            w_issue_nx = w_head[CW-1:3];
            w_rcnt_nx  = w_head[2:0];
          end else if (w_acc) begin
            // a command arriving on the final beat of an
            // otherwise empty queue chains on with no bubble
            w_push     = 1'b0;
            w_issue_nx = w_cmd[CW-1:3];
            w_rcnt_nx  = cmd_rep;
          end else begin
            w_state_nx = S_IDLE;
          end
        end
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  assign busy = (r_state == S_ISSUE);
  assign load = busy;
  assign in   = busy ? r_issue[IW-1:5] : '0;
  assign ch   = busy ? r_issue[4:3]    : '0;
  assign sh   = busy ? r_issue[2:1]    : '0;
  assign rg   = busy ? r_issue[0]      : 1'b0;
  // an aborted command never reports completion
  assign done = busy && (r_rcnt == 3'd0) && !flush;

endmodule

// File: tb/tb_shift_cmd_seq.sv
// Testbench for shift_cmd_seq against a command-queue model.
// Scenario tasks plus a randomized run; prints one summary line.
module tb_shift_cmd_seq;
  import shift_pkg::*;

  localparam int DEPTH = DEF_DEPTH;
  localparam int W     = DEF_W;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [W-1:0] cmd_data = '0;
  logic [1:0]   cmd_mode = '0;
  logic [1:0]   cmd_amt = '0;
  logic         cmd_ser = 1'b0;
  logic [2:0]   cmd_rep = '0;
  logic         flush = 1'b0;
  logic         load;
  logic [W-1:0] in;
  logic [1:0]   ch;
  logic [1:0]   sh;
  logic         rg;
  logic         busy;
  logic         done;
  logic [W+7:0] d_out;

  int checks = 0;
  int failures = 0;

  typedef struct {
    cmd_t c;
    int   rem;
  } ent_t;

  ent_t q[$];

  always #5 clk = ~clk;

  shift_cmd_seq #(.DEPTH(DEPTH), .W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_data  (cmd_data),
    .cmd_mode  (cmd_mode),
    .cmd_amt   (cmd_amt),
    .cmd_ser   (cmd_ser),
    .cmd_rep   (cmd_rep),
    .flush     (flush),
    .load      (load),
    .in        (in),
    .ch        (ch),
    .sh        (sh),
    .rg        (rg),
    .busy      (busy),
    .done      (done)
  );

  assign d_out = {load, in, ch, sh, rg, busy, done};

  // queue model: front entry is the issuing command,
  // the rest are waiting; rem counts beats still to go
  function automatic logic m_ready();
    int waiting;
    waiting = (q.size() == 0) ? 0 : q.size() - 1;
    return !reset && !flush && (waiting < DEPTH);
  endfunction

  function automatic logic [W+7:0] m_out();
    if (reset || q.size() == 0) return '0;
    return {1'b1, q[0].c.data, q[0].c.mode, q[0].c.amt,
            q[0].c.ser, 1'b1, (q[0].rem == 0) && !flush};
  endfunction

  task automatic drive(input logic v, input logic [W-1:0] d,
                       input logic [1:0] m, input logic [1:0] a,
                       input logic s, input logic [2:0] r);
    cmd_valid = v;
    cmd_data  = d;
    cmd_mode  = m;
    cmd_amt   = a;
    cmd_ser   = s;
    cmd_rep   = r;
  endtask

  task automatic idle();
    cmd_valid = 1'b0;
  endtask

  task automatic tick();
    logic acc;
    ent_t e;
    #1;
    acc = cmd_valid && m_ready();
    e.c.data = cmd_data;
    e.c.mode = mode_e'(cmd_mode);
    e.c.amt  = cmd_amt;
    e.c.ser  = cmd_ser;
    e.c.rep  = cmd_rep;
    e.rem    = int'(cmd_rep);
    @(posedge clk);
    if (reset || flush) begin
      q.delete();
    end else begin
      if (q.size() > 0) begin
        if (q[0].rem == 0) begin
          void'(q.pop_front());
        end else begin
          ent_t f;
          f = q[0];
          f.rem = f.rem - 1;
          q[0] = f;
        end
      end
      if (acc) q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (d_out !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h want=0", d_out);
    end
    checks++;
    if (cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready got=%b want=0", cmd_ready);
    end
  endtask

  task automatic test_bypass();
    logic [W+7:0] want;
    drive(1'b1, 4'b1010, 2'b01, 2'b01, 1'b0, 3'd0);
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL bypass_ready got=%b want=1", cmd_ready);
    end
    tick();
    idle();
    #1;
    want = {1'b1, 4'b1010, 2'b01, 2'b01, 1'b0, 1'b1, 1'b1};
    checks++;
    if (d_out !== want || d_out !== m_out()) begin
      failures++;
      $display("FAIL bypass_issue got=%h want=%h", d_out, want);
    end
    tick();
    #1;
    checks++;
    if (load !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL bypass_idle got load=%b busy=%b want 0 0",
               load, busy);
    end
  endtask

  task automatic test_repeat();
    int nload = 0;
    int nbusy = 0;
    logic [5:0] dmask = '0;
    drive(1'b1, W'($urandom), 2'b10, 2'b11, 1'b1, 3'd3);
    tick();
    idle();
    for (int i = 0; i < 6; i++) begin
      #1;
      nload += int'(load);
      nbusy += int'(busy);
      dmask[i] = done;
      checks++;
      if (d_out !== m_out()) begin
        failures++;
        $display("FAIL repeat_cycle%0d got=%h want=%h",
                 i, d_out, m_out());
      end
      tick();
    end
    checks++;
    if (nload != 4 || nbusy != 4 || dmask !== 6'b001000) begin
      failures++;
      $display("FAIL repeat_counts got load=%0d busy=%0d done=%b want 4 4 001000",
               nload, nbusy, dmask);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] modes [5];
    modes[0] = 2'b00;
    modes[1] = 2'b01;
    modes[2] = 2'b10;
    modes[3] = 2'b11;
    modes[4] = 2'b01;
    for (int i = 0; i < 6; i++) begin
      if (i < 5) drive(1'b1, W'(i), modes[i], 2'b00, 1'b0, 3'd0);
      else idle();
      #1;
      if (i > 0) begin
        checks++;
        if (ch !== modes[i-1] || load !== 1'b1 || done !== 1'b1) begin
          failures++;
          $display("FAIL b2b_beat%0d got ch=%b load=%b done=%b want ch=%b 1 1",
                   i, ch, load, done, modes[i-1]);
        end
      end
      if (i < 5) begin
        checks++;
        if (cmd_ready !== 1'b1) begin
          failures++;
          $display("FAIL b2b_ready%0d got=%b want=1", i, cmd_ready);
        end
      end
      tick();
    end
    #1;
    checks++;
    if (load !== 1'b0) begin
      failures++;
      $display("FAIL b2b_end got load=%b want=0", load);
    end
  endtask

  task automatic test_full();
    int n;
    drive(1'b1, 4'hF, 2'b11, 2'b10, 1'b1, 3'd7);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, W'(i), mode_e'(i), 2'b01, 1'b0, 3'd0);
      #1;
      checks++;
      if (cmd_ready !== 1'b1) begin
        failures++;
        $display("FAIL full_push%0d got ready=%b want=1", i, cmd_ready);
      end
      tick();
    end
    idle();
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (cmd_ready !== 1'b0 || d_out !== m_out()) begin
        failures++;
        $display("FAIL full_hold%0d got ready=%b out=%h want 0 %h",
                 k, cmd_ready, d_out, m_out());
      end
      tick();
    end
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL full_release got ready=%b want=1", cmd_ready);
    end
    n = 0;
    while (q.size() > 0 && n < 20) begin
      #1;
      checks++;
      if (d_out !== m_out()) begin
        failures++;
        $display("FAIL full_drain%0d got=%h want=%h", n, d_out, m_out());
      end
      tick();
      n++;
    end
    #1;
    checks++;
    if (busy !== 1'b0 || n >= 20) begin
      failures++;
      $display("FAIL full_end got busy=%b cycles=%0d want 0 <20", busy, n);
    end
  endtask

  task automatic test_flush();
    drive(1'b1, 4'h6, 2'b01, 2'b00, 1'b0, 3'd5);
    tick();
    drive(1'b1, 4'h1, 2'b10, 2'b01, 1'b0, 3'd0);
    tick();
    drive(1'b1, 4'h2, 2'b11, 2'b10, 1'b1, 3'd0);
    tick();
    idle();
    tick();
    flush = 1'b1;
    #1;
    checks++;
    if (done !== 1'b0 || cmd_ready !== 1'b0 || d_out !== m_out()) begin
      failures++;
      $display("FAIL flush_cycle got done=%b ready=%b want 0 0",
               done, cmd_ready);
    end
    tick();
    flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (load !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
          cmd_ready !== 1'b1) begin
        failures++;
        $display("FAIL flush_after%0d got load=%b busy=%b done=%b ready=%b want 0 0 0 1",
                 i, load, busy, done, cmd_ready);
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 4'h9, 2'b10, 2'b11, 1'b1, 3'd7);
    tick();
    idle();
    tick();
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (d_out !== '0 || cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got out=%h ready=%b want 0 0",
               d_out, cmd_ready);
    end
    q.delete();
    @(posedge clk);
    #3;
    reset = 1'b0;
    @(negedge clk);
    drive(1'b1, 4'h3, 2'b01, 2'b10, 1'b0, 3'd1);
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (d_out !== m_out()) begin
        failures++;
        $display("FAIL post_reset%0d got=%h want=%h", i, d_out, m_out());
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) < 6, W'($urandom), 2'($urandom),
            2'($urandom), 1'($urandom), 3'($urandom_range(0, 3)));
      flush = ($urandom_range(0, 29) == 0);
      #1;
      checks++;
      if (d_out !== m_out() || cmd_ready !== m_ready()) begin
        failures++;
        $display("FAIL random%0d got out=%h ready=%b want %h %b",
                 i, d_out, cmd_ready, m_out(), m_ready());
      end
      tick();
    end
    flush = 1'b0;
    idle();
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    reset = 1'b0;
    @(negedge clk);
    test_bypass();
    test_repeat();
    test_back_to_back();
    test_full();
    test_flush();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
